key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Parametrised N-channel debouncer/edge detector for the board's push-buttons and slide switches, in the clock_50 domain.
- Turns raw, asynchronous, bouncing contacts into clean synchronised levels plus one-cycle press and release pulses.
- Sits between the top-level key/sw pins and the keyboard/control logic.
- Generalises a fixed 4-key input path to any channel count, polarity and debounce time.

Parameters:
- CHANNELS, 4, number of independent input channels (1..32).
- CLK_HZ, 50_000_000, clock frequency in Hz.
- DEBOUNCE_US, 10_000, required stable time in microseconds.
- ACTIVE_LOW, 1, 1 = raw 0 means pressed (DE1 keys); 0 = raw 1 means pressed (switches).
- REPEAT_DELAY_US, 500_000, auto-repeat initial delay (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD_US, 100_000, auto-repeat period (used only with AUTO_REPEAT_EN).

Ports:
- clock_50  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- raw  in  CHANNELS  asynchronous contact inputs, polarity per ACTIVE_LOW.
- state  out  CHANNELS  debounced level, 1 = pressed, registered.
- press  out  CHANNELS  one-cycle pulse per accepted press (and per repeat if enabled).
- release  out  CHANNELS  one-cycle pulse per accepted release.

Behaviour:
- Clock and reset: one clock, clock_50. reset_n is synchronous and active-low, sampled on the rising edge of clock_50.
- Cycle constant: DB_CYC = CLK_HZ/1_000_000*DEBOUNCE_US, clamped to a minimum of 1.
- Counter width: $clog2(DB_CYC+1). Integer arithmetic only; no rounding beyond truncation.
- Input path: per channel, polarity normalised (inverted when ACTIVE_LOW=1), then a 2-flop synchroniser.
- Reset: synchroniser flops load "released" (0). state=0, press=0, release=0, all counters=0.
- Per-channel FSM:
  - STABLE: synchronised level == state; counter held at 0. A mismatch moves the FSM to CHANGING and sets counter=1.
  - CHANGING: mismatch continues → counter increments. Level returns to match state → counter cleared, back to STABLE, no output change (bounce rejected).
  - Accept: counter reaches DB_CYC while mismatch persists → on that edge state toggles, counter clears, FSM returns to STABLE.
  - Pulses: press=1 for exactly that cycle if state became 1; release=1 if state became 0.
- Latency: a clean level change on raw appears on state/press on the (2+DB_CYC)th rising edge after raw first presents the new level.
- press and release are never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-bounce discards all progress. After reset release, a raw input already held pressed is accepted after 2+DB_CYC cycles and produces a press pulse.
- A glitch shorter than DB_CYC cycles (after synchronisation) never changes state.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Per-channel repeat counter, with RD_CYC = CLK_HZ/1e6*REPEAT_DELAY_US and RP_CYC = CLK_HZ/1e6*REPEAT_PERIOD_US, each minimum 1.
  - While state=1: an extra press pulse fires RD_CYC cycles after the accepted press, then every RP_CYC cycles.
  - Release, or the reset_n assertion, clears the repeat counter immediately; no repeat pulse fires on the release cycle.
- Not defined: repeat logic and the REPEAT_* parameters are absent; press fires once per accepted press.

Test Plan:
All tests use CLK_HZ=1_000_000, DEBOUNCE_US=16 (DB_CYC=16), CHANNELS=4, ACTIVE_LOW=1.
- Clean press: raw[0] 1→0 and held → state[0] rises, with a single press[0] pulse, on edge 18 after the change; state[0] stays 1, no further pulses.
- Bounce rejection: raw[1] toggles low 10 cycles, high 3, low 10, then high → state[1] stays 0, press[1] never asserts.
- Release: from pressed, raw[0] 0→1 held → state[0] falls and release[0] pulses for 1 cycle on edge 18; press[0] stays 0.
- Multi-channel: raw[3:0] 1111→0000 on the same edge → press[3:0]=1111 on one identical cycle, then 0000.
- Reset mid-operation: raw[2] low for 10 cycles, then reset_n=0 for 2 cycles, then 1 → all outputs 0 during reset; press[2] fires 18 cycles after reset_n deassert.
- AUTO_REPEAT_EN, REPEAT_DELAY_US=50, REPEAT_PERIOD_US=20, raw[0] held low 200 cycles → press[0] pulses at edges 18, 68, 88, 108, ... Release stops pulses, and release[0] fires once.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: N-channel synchroniser/debouncer with one-cycle press and release pulses.
// Define AUTO_REPEAT_EN to add held-key auto-repeat press pulses.
module key_debounce #(
    parameter int CHANNELS         = 4,
    parameter int CLK_HZ           = 50_000_000,
    parameter int DEBOUNCE_US      = 10_000,
    parameter bit ACTIVE_LOW       = 1
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY_US  = 500_000,
    parameter int REPEAT_PERIOD_US = 100_000
`endif
) (
    input  logic                clock_50,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse
);
    localparam int DB_RAW = CLK_HZ / 1_000_000 * DEBOUNCE_US;
    localparam int DB_CYC = DB_RAW < 1 ? 1 : DB_RAW;
    localparam int CW     = $clog2(DB_CYC + 1);

    typedef enum logic {STABLE, CHANGING} fsm_t;

    fsm_t                fsm_q [CHANNELS];
    fsm_t                fsm_d [CHANNELS];
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CW-1:0]       nxt;
    logic [CHANNELS-1:0] level, sync1, sync2, accept, state_d, fire;

    assign level = ACTIVE_LOW ? ~raw : raw;

    // The count an edge would reach; hitting DB_CYC on that edge accepts the new level.
    always_comb begin
        accept = '0;
        nxt    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            fsm_d[i] = STABLE;
            cnt_d[i] = '0;
            nxt      = (fsm_q[i] == CHANGING ? cnt_q[i] : '0) + 1'b1;
            if (sync2[i] != state[i]) begin
                accept[i] = nxt == CW'(DB_CYC);
                fsm_d[i]  = accept[i] ? STABLE : CHANGING;
                cnt_d[i]  = accept[i] ? '0 : nxt;
            end
        end
        state_d = state ^ accept;
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            sync1         <= '0;
            sync2         <= '0;
            state         <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                fsm_q[i] <= STABLE;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1         <= level;
            sync2         <= sync1;
            state         <= state_d;
            press         <= (accept & state_d) | fire;
            release_pulse <= accept & ~state_d;
            for (int i = 0; i < CHANNELS; i++) begin
                fsm_q[i] <= fsm_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RD_RAW = CLK_HZ / 1_000_000 * REPEAT_DELAY_US;
    localparam int RP_RAW = CLK_HZ / 1_000_000 * REPEAT_PERIOD_US;
    localparam int RD_CYC = RD_RAW < 1 ? 1 : RD_RAW;
    localparam int RP_CYC = RP_RAW < 1 ? 1 : RP_RAW;
    localparam int RW     = $clog2((RD_CYC > RP_CYC ? RD_CYC : RP_CYC) + 1);

    logic [RW-1:0]       rc_q [CHANNELS];
    logic [RW-1:0]       rc_d [CHANNELS];
    logic [RW-1:0]       rnxt;
    logic [CHANNELS-1:0] rep_q, rep_d;

    // Any accept (press or release) restarts the delay; a release cycle never fires.
    always_comb begin
        fire  = '0;
        rep_d = '0;
        rnxt  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rc_d[i] = '0;
            if (state[i] && !accept[i]) begin
                rnxt     = rc_q[i] + 1'b1;
                fire[i]  = rnxt == (rep_q[i] ? RW'(RP_CYC) : RW'(RD_CYC));
                rc_d[i]  = fire[i] ? '0 : rnxt;
                rep_d[i] = rep_q[i] | fire[i];
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            rep_q <= '0;
            for (int i = 0; i < CHANNELS; i++) rc_q[i] <= '0;
        end else begin
            rep_q <= rep_d;
            for (int i = 0; i < CHANNELS; i++) rc_q[i] <= rc_d[i];
        end
    end
`else
    assign fire = '0;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; expected pulse events are queued when raw is driven
// and matched against every nonzero press/release the DUT emits.
module tb_key_debounce;
    logic       clock_50 = 1'b0;
    logic       reset_n;
    logic [3:0] raw;
    logic [3:0] state, press, release_pulse;
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] s;
    } ev_t;
    ev_t q[$];

    key_debounce #(
        .CHANNELS(4),
        .CLK_HZ(1_000_000),
        .DEBOUNCE_US(16),
        .ACTIVE_LOW(1)
`ifdef AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY_US(50),
        .REPEAT_PERIOD_US(20)
`endif
    ) dut (
        .clock_50(clock_50),
        .reset_n(reset_n),
        .raw(raw),
        .state(state),
        .press(press),
        .release_pulse(release_pulse)
    );

    always #5 clock_50 = ~clock_50;
    always @(posedge clock_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic expect_ev(input int dt, input logic [3:0] p, input logic [3:0] r, input logic [3:0] s);
        q.push_back('{cyc + dt, p, r, s});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_50);
    endtask

    always @(negedge clock_50) begin
        if ((press | release_pulse) != 4'b0) begin
            if (q.size() == 0) begin
                check("spurious", {24'b0, press, release_pulse}, 32'b0);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_press", {28'b0, press}, {28'b0, e.p});
                check("ev_release", {28'b0, release_pulse}, {28'b0, e.r});
                check("ev_state", {28'b0, state}, {28'b0, e.s});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        raw     = 4'hF;
        idle(3);
        check("rst_state", {28'b0, state}, 32'h0);
        check("rst_press", {28'b0, press}, 32'h0);
        check("rst_release", {28'b0, release_pulse}, 32'h0);
        reset_n = 1'b1;
        idle(20);
        check("idle_state", {28'b0, state}, 32'h0);

        // clean press then release on channel 0
        raw[0] = 1'b0;
        expect_ev(18, 4'b0001, 4'b0000, 4'b0001);
        idle(30);
        check("press_held", {28'b0, state}, 32'h1);
        raw[0] = 1'b1;
        expect_ev(18, 4'b0000, 4'b0001, 4'b0000);
        idle(30);
        check("released", {28'b0, state}, 32'h0);

        // bounce on channel 1 never accepted
        raw[1] = 1'b0; idle(10);
        raw[1] = 1'b1; idle(3);
        raw[1] = 1'b0; idle(10);
        raw[1] = 1'b1; idle(30);
        check("bounce", {28'b0, state}, 32'h0);

        // glitch boundary on channel 3: 15 cycles rejected, 16 accepted
        raw[3] = 1'b0; idle(15);
        raw[3] = 1'b1; idle(30);
        check("glitch15", {28'b0, state}, 32'h0);
        raw[3] = 1'b0;
        expect_ev(18, 4'b1000, 4'b0000, 4'b1000);
        idle(16);
        raw[3] = 1'b1;
        expect_ev(18, 4'b0000, 4'b1000, 4'b0000);
        idle(30);
        check("glitch16", {28'b0, state}, 32'h0);

        // all channels together
        raw = 4'h0;
        expect_ev(18, 4'b1111, 4'b0000, 4'b1111);
        idle(25);
        check("multi_held", {28'b0, state}, 32'hF);
        raw = 4'hF;
        expect_ev(18, 4'b0000, 4'b1111, 4'b0000);
        idle(25);
        check("multi_rel", {28'b0, state}, 32'h0);

        // reset mid-debounce discards progress
        raw[2] = 1'b0;
        idle(10);
        reset_n = 1'b0;
        idle(1);
        check("midrst_state", {28'b0, state}, 32'h0);
        check("midrst_press", {28'b0, press}, 32'h0);
        idle(1);
        check("midrst_release", {28'b0, release_pulse}, 32'h0);
        reset_n = 1'b1;
        expect_ev(18, 4'b0100, 4'b0000, 4'b0100);
        idle(25);
        raw[2] = 1'b1;
        expect_ev(18, 4'b0000, 4'b0100, 4'b0000);
        idle(25);

`ifdef AUTO_REPEAT_EN
        raw[0] = 1'b0;
        expect_ev(18, 4'b0001, 4'b0000, 4'b0001);
        for (int k = 0; k < 8; k++) expect_ev(68 + 20 * k, 4'b0001, 4'b0000, 4'b0001);
        idle(200);
        raw[0] = 1'b1;
        expect_ev(18, 4'b0000, 4'b0001, 4'b0000);
        idle(40);
        check("repeat_rel", {28'b0, state}, 32'h0);
`endif

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clock_50);
        check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
